// File: rtl/xor8_descrambler.sv
// Byte-wide additive descrambler (x^7 + x^4 + 1). It checks an XOR parity trailer per frame
// and drives a single registered valid/ready output stage.
module xor8_descrambler #(
  parameter logic [6:0] SEED         = 7'h7F,
  parameter bit         CHECK_PARITY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seed_load,
  input  logic [6:0] seed,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       out_err,
  output logic [7:0] frame_len
);

  // Eight serial LFSR steps; returns {state after 8 steps, keystream byte with k_0 as LSB}
  function automatic logic [14:0] lfsr_run8(input logic [6:0] s);
    logic [6:0] st;
    logic [7:0] ks;
    logic       k;
    st = s;
    ks = 8'h00;
    for (int i = 0; i < 8; i++) begin
      k     = st[6] ^ st[3];
      ks[i] = k;
      st    = {st[5:0], k};
    end
    return {st, ks};
  endfunction

  // An all-zero seed would lock the LFSR, so it falls back to SEED
  function automatic logic [6:0] seed_guard(input logic [6:0] s);
    return (s == 7'h00) ? SEED : s;
  endfunction

  function automatic logic parity_mismatch(input logic [7:0] trailer, input logic [7:0] acc);
    return |(trailer ^ acc);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? 8'hFF : c + 8'd1;
  endfunction

  logic [6:0] lfsr_r;
  logic [7:0] acc_r;
  logic [7:0] count_r;
  logic       out_valid_r;
  logic [7:0] out_data_r;
  logic       out_last_r;
  logic       out_err_r;
  logic [7:0] frame_len_r;

  logic       in_ready_s;
  logic       accept_s;
  logic [6:0] lfsr_adv_s;
  logic [7:0] ks_s;
  logic [7:0] plain_s;
  logic [6:0] lfsr_nxt_s;

  // Handshake, keystream and next-LFSR selection (seed_load overrides any beat-driven update)
  always_comb begin
    in_ready_s           = !out_valid_r || out_ready;
    accept_s             = in_valid && in_ready_s;
    {lfsr_adv_s, ks_s}   = lfsr_run8(lfsr_r);
    plain_s              = in_data ^ ks_s;
    lfsr_nxt_s           = lfsr_r;
    if (seed_load) begin
      lfsr_nxt_s = seed_guard(seed);
    end else if (accept_s && in_last) begin
      lfsr_nxt_s = SEED;
    end else if (accept_s) begin
      lfsr_nxt_s = lfsr_adv_s;
    end else begin
      lfsr_nxt_s = lfsr_r;
    end
  end

  // Output stage, frame parity accumulator and data-byte counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r      <= SEED;
      acc_r       <= 8'h00;
      count_r     <= 8'h00;
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
      out_last_r  <= 1'b0;
      out_err_r   <= 1'b0;
      frame_len_r <= 8'h00;
    end else begin
      lfsr_r <= lfsr_nxt_s;
      if (accept_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= plain_s;
        out_last_r  <= in_last;
        if (in_last) begin
          out_err_r   <= CHECK_PARITY ? parity_mismatch(plain_s, acc_r) : 1'b0;
          frame_len_r <= count_r;
          acc_r       <= 8'h00;
          count_r     <= 8'h00;
        end else begin
          acc_r   <= acc_r ^ plain_s;
          count_r <= sat_inc(count_r);
        end
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign out_err   = out_err_r;
  assign frame_len = frame_len_r;

endmodule

// File: tb/tb_xor8_descrambler.sv
// Randomized bench for xor8_descrambler. The reference keeps the keystream as a bit
// history obeying b[n] = b[n-7] ^ b[n-4] and tracks the frame parity and length.
module tb_xor8_descrambler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       seed_load;
  logic [6:0] seed;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_err;
  logic [7:0] frame_len;

  always #5 clk = ~clk;

  xor8_descrambler dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_err(out_err), .frame_len(frame_len)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit         hist[$];
  logic       m_ov, m_ol, m_oe;
  logic [7:0] m_od, m_acc, m_fl;
  int         m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reseed(input logic [6:0] s);
    hist.delete();
    for (int i = 6; i >= 0; i--) hist.push_back(s[i]);
  endtask

  function automatic logic [7:0] peek_ks();
    bit h[$];
    bit b;
    logic [7:0] k;
    h = hist;
    k = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b = h[h.size()-7] ^ h[h.size()-4];
      h.push_back(b);
      k[i] = b;
    end
    return k;
  endfunction

  task automatic advance(input logic [7:0] k);
    for (int i = 0; i < 8; i++) begin
      hist.push_back(k[i]);
      void'(hist.pop_front());
    end
  endtask

  task automatic model_reset();
    m_ov = 1'b0; m_ol = 1'b0; m_oe = 1'b0;
    m_od = 8'h00; m_acc = 8'h00; m_fl = 8'h00; m_cnt = 0;
    reseed(7'h7F);
  endtask

  task automatic check_outputs();
    check_eq("out_valid", out_valid, m_ov);
    check_eq("out_data", out_data, m_od);
    check_eq("out_last", out_last, m_ol);
    check_eq("out_err", out_err, m_oe);
    check_eq("frame_len", frame_len, m_fl);
  endtask

  // One clock: drive at posedge+1, check in_ready, update the model, check outputs at next posedge+1
  task automatic step(input logic v, input logic [7:0] d, input logic l, input logic ordy,
                      input logic sl, input logic [6:0] sd);
    logic acc_ok;
    logic [7:0] k, pd;
    in_valid = v; in_data = d; in_last = l; out_ready = ordy; seed_load = sl; seed = sd;
    #1;
    acc_ok = v && (!m_ov || ordy);
    check_eq("in_ready", in_ready, (!m_ov || ordy));
    if (acc_ok) begin
      k = peek_ks();
      advance(k);
      pd = d ^ k;
      m_od = pd; m_ol = l; m_ov = 1'b1;
      if (l) begin
        m_oe = (pd != m_acc);
        m_fl = m_cnt[7:0];
        m_acc = 8'h00; m_cnt = 0;
        reseed(7'h7F);
      end else begin
        m_acc = m_acc ^ pd;
        if (m_cnt < 255) m_cnt++;
      end
    end else if (m_ov && ordy) begin
      m_ov = 1'b0;
    end
    if (sl) reseed((sd == 7'h00) ? 7'h7F : sd);
    @(posedge clk);
    #1;
    check_outputs();
    seed_load = 1'b0;
    in_valid = 1'b0;
  endtask

  // Scramble a plaintext byte with the expected keystream, as the transmitter would
  task automatic send_plain(input logic [7:0] p, input logic l, input logic ordy,
                            input logic sl, input logic [6:0] sd);
    step(1'b1, p ^ peek_ks(), l, ordy, sl, sd);
  endtask

  task automatic close_frame();
    send_plain(m_acc, 1'b1, 1'b1, 1'b0, 7'h00);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 7'h00);
  endtask

  initial begin
    logic v, l, ordy, sl;
    logic [6:0] sd;
    logic [7:0] d, tgt;

    rst_n = 1'b0; seed_load = 1'b0; seed = 7'h00; in_valid = 1'b0;
    in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_outputs();
    rst_n = 1'b1;

    // Known keystream from SEED
    step(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 7'h00);
    check_eq("ks_byte0", out_data, 8'h70);
    step(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 7'h00);
    check_eq("ks_byte1", out_data, 8'h4F);
    close_frame();
    check_eq("f0_err", out_err, 1'b0);
    check_eq("f0_len", frame_len, 8'd2);
    idle();

    // Good frame
    send_plain(8'h12, 1'b0, 1'b1, 1'b0, 7'h00);
    check_eq("f1_b0", out_data, 8'h12);
    send_plain(8'h34, 1'b0, 1'b1, 1'b0, 7'h00);
    check_eq("f1_b1", out_data, 8'h34);
    send_plain(8'h26, 1'b1, 1'b1, 1'b0, 7'h00);
    check_eq("f1_tr", out_data, 8'h26);
    check_eq("f1_last", out_last, 1'b1);
    check_eq("f1_err", out_err, 1'b0);
    check_eq("f1_len", frame_len, 8'd2);

    // Corrupted trailer, then next frame from SEED
    send_plain(8'h12, 1'b0, 1'b1, 1'b0, 7'h00);
    send_plain(8'h34, 1'b0, 1'b1, 1'b0, 7'h00);
    send_plain(8'h27, 1'b1, 1'b1, 1'b0, 7'h00);
    check_eq("f2_err", out_err, 1'b1);
    check_eq("f2_len", frame_len, 8'd2);
    step(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 7'h00);
    check_eq("f3_ks0", out_data, 8'h70);
    send_plain(8'h70, 1'b1, 1'b1, 1'b0, 7'h00);
    check_eq("f3_err", out_err, 1'b0);
    idle();

    // Stall: first byte accepted, then held for two more cycles
    send_plain(8'hA5, 1'b0, 1'b0, 1'b0, 7'h00);
    check_eq("stall_acc", out_data, 8'hA5);
    for (int i = 0; i < 2; i++) begin
      send_plain(8'h5A, 1'b0, 1'b0, 1'b0, 7'h00);
      check_eq("stall_hold", out_data, 8'hA5);
      check_eq("stall_rdy", in_ready, 1'b0);
    end
    send_plain(8'h5A, 1'b0, 1'b1, 1'b0, 7'h00);
    check_eq("stall_rel", out_data, 8'h5A);
    send_plain(8'hC3, 1'b0, 1'b1, 1'b0, 7'h00);
    check_eq("stall_next", out_data, 8'hC3);
    close_frame();
    check_eq("stall_err", out_err, 1'b0);
    check_eq("stall_len", frame_len, 8'd3);
    idle();

    // seed_load with zero seed while idle, then together with accepted beats
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 7'h00);
    step(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 7'h00);
    check_eq("sl0_ks", out_data, 8'h70);
    step(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 7'h55);
    check_eq("sl_same", out_data, 8'h4F);
    send_plain(8'h3C, 1'b0, 1'b1, 1'b0, 7'h00);
    check_eq("sl_new", out_data, 8'h3C);
    send_plain(m_acc, 1'b1, 1'b1, 1'b1, 7'h2A);
    check_eq("sl_last_err", out_err, 1'b0);
    send_plain(8'h99, 1'b0, 1'b1, 1'b0, 7'h00);
    close_frame();
    idle();

    // Length saturation
    for (int i = 0; i < 300; i++) send_plain(8'($urandom), 1'b0, 1'b1, 1'b0, 7'h00);
    close_frame();
    check_eq("sat_len", frame_len, 8'd255);
    check_eq("sat_err", out_err, 1'b0);
    idle();

    // Reset mid-frame with out_valid high
    send_plain(8'h11, 1'b0, 1'b1, 1'b0, 7'h00);
    send_plain(8'h22, 1'b0, 1'b1, 1'b0, 7'h00);
    check_eq("pre_rst_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 7'h00);
    check_eq("post_rst_ks", out_data, 8'h70);
    send_plain(8'h00, 1'b1, 1'b1, 1'b0, 7'h00);
    check_eq("one_beat_err", out_err, 1'b0);
    check_eq("one_beat_len", frame_len, 8'd0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      l    = ($urandom_range(0, 5) == 0);
      sl   = ($urandom_range(0, 15) == 0);
      sd   = 7'($urandom_range(0, 127));
      if (l) begin
        tgt = m_acc;
        if ($urandom_range(0, 3) == 0) tgt = tgt ^ (8'h01 << $urandom_range(0, 7));
        d = tgt ^ peek_ks();
      end else begin
        d = 8'($urandom);
      end
      step(v, d, l, ordy, sl, sd);
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/xor8_descrambler.md
Name: xor8_descrambler

Overview:
Byte-wide receive-side descrambler. It is the inverse of the additive XOR scrambler on the transmit path. Each accepted byte is XORed with an 8-bit keystream from a 7-bit LFSR (x^7 + x^4 + 1, 802.11 form). The block also checks a per-frame XOR parity trailer and forwards descrambled bytes through a single registered valid/ready stage.

Parameters:
SEED, 7'h7F, LFSR value loaded at reset, after every accepted in_last beat, and on seed_load when seed is unused (see seed_load)
CHECK_PARITY, 1, 1 = last byte of each frame is a parity trailer and out_err is computed; 0 = out_err held at 0

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
seed_load  input  1  one-cycle pulse; loads LFSR from seed
seed  input  7  value loaded on seed_load; if 7'h00, SEED is loaded instead (all-zero lock-up guard)
in_valid  input  1  input byte valid
in_ready  output  1  block can accept a byte
in_data  input  8  scrambled byte
in_last  input  1  marks final byte (parity trailer) of a frame
out_valid  output  1  output byte valid
out_ready  input  1  downstream accepts output
out_data  output  8  descrambled byte
out_last  output  1  final byte of a frame
out_err  output  1  parity mismatch; meaningful only with out_last
frame_len  output  8  data-byte count of the frame just completed (excludes trailer), saturates at 255; valid with out_last

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_last=0, out_err=0, frame_len=0, LFSR=SEED, parity acc=0, byte count=0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - An input beat is accepted when in_valid && in_ready.
  - An output beat is consumed when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_* hold stable.
- Latency: one cycle from input accept to out_valid. Back-to-back throughput is 1 byte/cycle while out_ready=1.
- Keystream per accepted beat, 8 serial LFSR steps in one cycle:
  - Step i, i=0..7: k_i = s[6]^s[3]; s <= {s[5:0], k_i}.
  - Keystream byte = {k_7..k_0}, so k_0 is the LSB.
  - out_data = in_data ^ keystream. From seed 7'h7F the first two keystream bytes are 8'h70, then 8'h4F.
  - The LFSR advances only on an accepted beat. Stalls do not advance it.
- Parity, CHECK_PARITY=1:
  - Accepted non-last beat: acc <= acc ^ out_data, count <= count+1 (saturating at 255).
  - Accepted last beat: out_err <= (descrambled byte != acc), frame_len <= count. acc, count and LFSR are then reset to 0, 0 and SEED.
  - A frame of one beat (in_last on the first byte) checks against acc=0.
- out_last follows in_last with the same latency. out_err and frame_len update only on last beats and hold until the next last beat.
- seed_load:
  - Pulse while idle: LFSR <= seed (or SEED if seed=0). acc and count are unaffected.
  - seed_load in the same cycle as an accepted beat: the beat uses the current LFSR state, then seed_load overrides the post-beat LFSR value.
  - seed_load in the same cycle as an accepted in_last beat: seed_load takes priority over the reseed to SEED.
- Reset mid-frame: the in-flight output beat is dropped. acc, count and LFSR return to their reset values. No out_err is generated for the aborted frame.
- No combinational path from in_data to out_data. All out_* are registered.

Test Plan:
- Reset, then in_data=8'h00, 8'h00 accepted back-to-back (out_ready=1) -> out_data=8'h70, then 8'h4F, each one cycle after accept; in_ready stays 1.
- Feed the scrambler's output for plaintext 8'h12, 8'h34, trailer 8'h26 with in_last -> out_data 8'h12, 8'h34, 8'h26; out_last on the third beat; out_err=0; frame_len=2.
- Same frame with the trailer's plaintext corrupted to 8'h27 -> out_err=1 with out_last, frame_len=2. The next frame descrambles from SEED correctly.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 after the first accept, out_data stable, LFSR not advanced. Releasing out_ready resumes the correct keystream sequence with no lost or duplicated bytes.
- seed_load with seed=7'h00 -> LFSR=7'h7F, so the next keystream byte is 8'h70. seed_load in the same cycle as an accepted beat -> that beat uses the old state, and the following beat uses the new seed.
- Assert rst_n=0 mid-frame, with out_valid=1, after 2 data bytes -> all outputs 0 immediately. The first post-reset byte 8'h00 gives 8'h70, and a one-beat frame with a 8'h00 plaintext trailer gives out_err=0, frame_len=0.
